// File: rtl/rot_req_if.sv
// Handshake bundle between the request producer, the request queue and the
// rotator-side consumer of rot_req_fifo.
interface rot_req_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_a;
  logic [1:0]    in_shl;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    A;
  logic [1:0]    shl;
  logic [CW-1:0] count;
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output in_valid, in_a, in_shl, out_ready, ovf_clr,
    input  in_ready, out_valid, A, shl, count, ovf
  );

  modport slave (
    input  in_valid, in_a, in_shl, out_ready, ovf_clr,
    output in_ready, out_valid, A, shl, count, ovf
  );
endinterface

// File: rtl/rot_req_fifo.sv
// Request queue feeding the 4-bit left-rotate stage: buffers DEPTH
// {operand, rotate amount} entries and presents the oldest on A/shl.
module rot_req_fifo #(
  parameter int DEPTH = 4
) (
  input logic      clk,
  input logic      rst_n,
  rot_req_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a transfer happens at a rising edge when valid and ready are
  // both high; ready never looks at valid, so no input-to-output paths exist.
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [5:0]    head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_a, bus.in_shl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // An offer against a full queue outranks a clear at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid && full) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.A         = empty ? 4'b0000 : head[5:2];
  assign bus.shl       = empty ? 2'b00   : head[1:0];
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rot_req_fifo.sv
// Directed bench for rot_req_fifo: a reference queue tracks what the head
// should be after every edge, plus the fixed cases from the block's test plan.
module tb_rot_req_fifo;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  rot_req_if #(.DEPTH(DEPTH)) bus ();

  rot_req_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [5:0] exp_q[$];
  int         mcount;
  logic       movf;
  int         n_cmp;
  int         n_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] a, input logic [1:0] s);
    logic [7:0] t;
    t = {a, a} << s;
    return t[7:4];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"},  8'(bus.in_ready),  8'd1);
    chk({tag, "_out_valid"}, 8'(bus.out_valid), 8'd0);
    chk({tag, "_A"},         8'(bus.A),         8'd0);
    chk({tag, "_shl"},       8'(bus.shl),       8'd0);
    chk({tag, "_count"},     8'(bus.count),     8'd0);
    chk({tag, "_ovf"},       8'(bus.ovf),       8'd0);
  endtask

  // driver: called at posedge+#1; applies one cycle of inputs and checks
  // handshake flags before the edge and head/count/ovf after it
  task automatic step(input logic v, input logic [3:0] a, input logic [1:0] s,
                      input logic r, input logic clr);
    logic       was_full;
    logic       do_push;
    logic       do_pop;
    logic [5:0] head;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_shl    = s;
    bus.out_ready = r;
    bus.ovf_clr   = clr;
    #1;
    was_full = (mcount == DEPTH);
    chk("in_ready",  8'(bus.in_ready),  8'(!was_full));
    chk("out_valid", 8'(bus.out_valid), 8'(mcount != 0));
    do_push = v && !was_full;
    do_pop  = r && (mcount != 0);
    @(posedge clk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({a, s});
    mcount = mcount + int'(do_push) - int'(do_pop);
    if (v && was_full) movf = 1'b1;
    else if (clr)      movf = 1'b0;
    #1;
    head = (exp_q.size() != 0) ? exp_q[0] : 6'd0;
    chk("count",    8'(bus.count), 8'(mcount));
    chk("head_a",   8'(bus.A),     8'(head[5:2]));
    chk("head_shl", 8'(bus.shl),   8'(head[1:0]));
    chk("ovf",      8'(bus.ovf),   8'(movf));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
  endtask

  logic [3:0] fill_a   [4];
  logic [1:0] fill_shl [4];
  logic [3:0] rot_exp  [4];
  logic [3:0] ra;
  logic [1:0] rs;

  initial begin
    n_cmp = 0;
    n_err = 0;
    fill_a   = '{4'd1, 4'd2, 4'd4, 4'd8};
    fill_shl = '{2'd0, 2'd1, 2'd2, 2'd3};
    rot_exp  = '{4'd1, 4'd4, 4'd1, 4'd4};
    bus.in_valid  = 1'b0;
    bus.in_a      = 4'd0;
    bus.in_shl    = 2'd0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // reset asserted between clock edges: outputs must follow at once
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill to DEPTH with no pops
    for (int i = 0; i < 4; i++) step(1'b1, fill_a[i], fill_shl[i], 1'b0, 1'b0);
    chk("fill_count",    8'(bus.count),    8'd4);
    chk("fill_in_ready", 8'(bus.in_ready), 8'd0);

    // drain: head order and rotator result per entry
    for (int i = 0; i < 4; i++) begin
      chk("drain_rot", 8'(rotl(bus.A, bus.shl)), 8'(rot_exp[i]));
      step(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    end
    chk("drain_A", 8'(bus.A), 8'd0);

    // pop while empty is ignored
    step(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);

    // count=2, then sustained push+pop; pointers wrap past DEPTH-1
    for (int i = 0; i < 2; i++) begin
      ra = 4'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));
      step(1'b1, ra, rs, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      ra = 4'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));
      step(1'b1, ra, rs, 1'b1, 1'b0);
      chk("pp_count", 8'(bus.count), 8'd2);
    end

    // full with out_ready: pop only, ovf set; then same inputs move both
    for (int i = 0; i < 2; i++) step(1'b1, 4'(i + 9), 2'(i), 1'b0, 1'b0);
    step(1'b1, 4'hc, 2'd3, 1'b1, 1'b0);
    chk("full_pop_count", 8'(bus.count), 8'd3);
    chk("full_pop_ovf",   8'(bus.ovf),   8'd1);
    step(1'b1, 4'hc, 2'd3, 1'b1, 1'b0);
    chk("full_pp_count",  8'(bus.count), 8'd3);

    // ovf clear alone, then clear colliding with a fresh overflow
    step(1'b0, 4'd0, 2'd0, 1'b0, 1'b1);
    chk("ovf_clr", 8'(bus.ovf), 8'd0);
    step(1'b1, 4'h7, 2'd2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 2'd1, 1'b0, 1'b1);
    chk("ovf_set_wins", 8'(bus.ovf), 8'd1);

    // reset mid-traffic at count=3
    step(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    chk("pre_rst_count", 8'(bus.count), 8'd3);
    rst_n = 1'b0;
    #1 reset_checks("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 4'd5, 2'd1, 1'b0, 1'b0);
    chk("post_rst_A",     8'(bus.A),     8'd5);
    chk("post_rst_shl",   8'(bus.shl),   8'd1);
    chk("post_rst_count", 8'(bus.count), 8'd1);
    step(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
